// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
//==============================================================================
// Module  : dmem_arbiter_pkg
// Brief   : Shared types, byte-mask constants and alignment check for the
//           data-memory arbiter.
// Revision: 1.0
//==============================================================================
package dmem_arbiter_pkg;

   localparam int NREQ = 2;

   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10
   } size_e;

   localparam logic [3:0] MASK_B = 4'b0001;
   localparam logic [3:0] MASK_H = 4'b0011;
   localparam logic [3:0] MASK_W = 4'b1111;

   // Encoding 2'b11 has no access width, so it reports as misaligned.
   function automatic logic is_misaligned(input logic [1:0] size,
                                          input logic [1:0] lane);
      logic mis;
      case (size)
         SZ_B:    mis = 1'b0;
         SZ_H:    mis = lane[0];
         SZ_W:    mis = |lane;
         default: mis = 1'b1;
      endcase
      return mis;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
//==============================================================================
// Module  : dmem_arbiter_if
// Brief   : Two-port request/response bundle between requesters and arbiter.
// Revision: 1.0
//==============================================================================
interface dmem_arbiter_if;
   import dmem_arbiter_pkg::*;

   logic [NREQ-1:0]        req_valid;
   logic [NREQ-1:0]        req_ready;
   logic [NREQ-1:0]        req_we;
   logic [NREQ-1:0][1:0]   req_size;
   logic [NREQ-1:0]        req_unsigned;
   logic [NREQ-1:0][31:0]  req_addr;
   logic [NREQ-1:0][31:0]  req_wdata;
   logic [NREQ-1:0]        resp_valid;
   logic                   resp_err;
   logic [31:0]            resp_rdata;

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_err, resp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      output req_ready, resp_valid, resp_err, resp_rdata
   );

endinterface
`default_nettype wire

// File: rtl/dmem_lane_steer.sv
`default_nettype none
//==============================================================================
// Module  : dmem_lane_steer
// Brief   : Byte-lane steering: store mask/data replication and load
//           lane extraction with sign/zero extension.
// Revision: 1.0
//==============================================================================
module dmem_lane_steer
   import dmem_arbiter_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  lane,
   input  logic        is_unsigned,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  wmask,
   output logic [31:0] wd,
   output logic [31:0] ext
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      wmask  = 4'b0000;
      wd     = 32'h0;
      ext    = 32'h0;
      w_byte = rdata[{lane, 3'b000} +: 8];
      w_half = rdata[{lane[1], 4'b0000} +: 16];
      case (size)
         SZ_B: begin
            wmask = MASK_B << lane;
            wd    = {4{wdata[7:0]}};
            ext   = is_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
         end
         SZ_H: begin
            wmask = MASK_H << {lane[1], 1'b0};
            wd    = {2{wdata[15:0]}};
            ext   = is_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
         end
         SZ_W: begin
            wmask = MASK_W;
            wd    = wdata;
            ext   = rdata;
         end
         default: begin
            wmask = 4'b0000;
            wd    = 32'h0;
            ext   = 32'h0;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
//==============================================================================
// Module  : dmem_arbiter
// Brief   : Two-requester arbiter in front of a single-port byte-maskable
//           data memory, with one-cycle registered responses.
// Revision: 1.0
//==============================================================================
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int WADDR_W    = 8,
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic               clk,
   input  logic               rst_n,
   dmem_arbiter_if.slave      bus,
   output logic [WADDR_W-1:0] mem_addr,
   output logic [3:0]         mem_wmask,
   output logic [31:0]        mem_wd,
   input  logic [31:0]        mem_rd
);

   logic [NREQ-1:0] w_grant;
   logic            w_gid;
   logic            w_accept;
   logic            w_we;
   logic [1:0]      w_size;
   logic            w_unsigned;
   logic [31:0]     w_addr;
   logic [31:0]     w_wdata;
   logic            w_mis;
   logic [3:0]      w_st_mask;
   logic [31:0]     w_ld_ext;
   logic            w_resp_live;

   logic            r_last_grant;
   logic [NREQ-1:0] r_valid;
   logic            r_err;
   logic            r_is_load;
   logic [1:0]      r_size;
   logic [1:0]      r_lane;
   logic            r_unsigned;
   logic [31:0]     r_rd;

   logic [31:0]     w_unused_st_ext;
   logic [3:0]      w_unused_ld_mask;
   logic [31:0]     w_unused_ld_wd;
   logic            w_unused_addr_hi;

   // Holding reset also withholds every grant, so nothing writes memory.
   always_comb begin
      w_grant = '0;
      if (rst_n) begin
         case (bus.req_valid)
            2'b01:   w_grant = 2'b01;
            2'b10:   w_grant = 2'b10;
            2'b11:   w_grant = (FIXED_PRIO || r_last_grant) ? 2'b01 : 2'b10;
            default: w_grant = 2'b00;
         endcase
      end
   end

   assign w_accept      = |w_grant;
   assign w_gid         = w_grant[1];
   assign bus.req_ready = w_grant;

   assign w_we       = bus.req_we[w_gid];
   assign w_size     = bus.req_size[w_gid];
   assign w_unsigned = bus.req_unsigned[w_gid];
   assign w_addr     = bus.req_addr[w_gid];
   assign w_wdata    = bus.req_wdata[w_gid];
   assign w_mis      = is_misaligned(w_size, w_addr[1:0]);

   dmem_lane_steer u_store_steer (
      .size        (w_size),
      .lane        (w_addr[1:0]),
      .is_unsigned (1'b0),
      .wdata       (w_wdata),
      .rdata       (32'h0),
      .wmask       (w_st_mask),
      .wd          (mem_wd),
      .ext         (w_unused_st_ext)
   );

   assign mem_addr         = w_addr[WADDR_W+1:2];
   assign mem_wmask        = (w_accept && w_we && !w_mis) ? w_st_mask : 4'b0000;
   assign w_unused_addr_hi = ^w_addr[31:WADDR_W+2];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_last_grant <= 1'b1;
      end else if (w_accept) begin
         r_last_grant <= w_gid;
      end
   end

   // Raw word is captured; lane extraction happens on the registered side.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_valid    <= '0;
         r_err      <= 1'b0;
         r_is_load  <= 1'b0;
         r_size     <= 2'b00;
         r_lane     <= 2'b00;
         r_unsigned <= 1'b0;
         r_rd       <= 32'h0;
      end else begin
         r_valid <= w_grant;
         if (w_accept) begin
            r_err      <= w_mis;
            r_is_load  <= !w_we;
            r_size     <= w_size;
            r_lane     <= w_addr[1:0];
            r_unsigned <= w_unsigned;
            r_rd       <= mem_rd;
         end
      end
   end

   dmem_lane_steer u_load_steer (
      .size        (r_size),
      .lane        (r_lane),
      .is_unsigned (r_unsigned),
      .wdata       (32'h0),
      .rdata       (r_rd),
      .wmask       (w_unused_ld_mask),
      .wd          (w_unused_ld_wd),
      .ext         (w_ld_ext)
   );

   // Reset during the response cycle suppresses the pending response.
   assign w_resp_live    = rst_n && (|r_valid);
   assign bus.resp_valid = rst_n ? r_valid : '0;
   assign bus.resp_err   = w_resp_live && r_err;
   assign bus.resp_rdata = (w_resp_live && r_is_load && !r_err) ? w_ld_ext : 32'h0;

endmodule
`default_nettype wire
